// File: rtl/accumulation_pkg.sv
// Shared types and helpers for the block accumulator: FSM state, add modes,
// and the sample-count width function.
package accumulation_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Bits needed to hold values 0..n inclusive, never less than 1.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < (n + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/accum_sat_add.sv
// Combinational accumulator adder: acc + zero-extended sample, with carry-out
// reported as overflow and an optional clamp to all-ones.
module accum_sat_add
  import accumulation_pkg::*;
#(
  parameter int DIN_W  = 4,
  parameter int DOUT_W = 8,
  parameter int SAT_EN = MODE_SAT
) (
  input  logic [DOUT_W-1:0] a,
  input  logic [DIN_W-1:0]  b,
  output logic [DOUT_W-1:0] sum,
  output logic              ovf
);

  logic [DOUT_W:0] full;

  assign full = {1'b0, a} + {{(DOUT_W - DIN_W + 1){1'b0}}, b};
  assign ovf  = full[DOUT_W];
  assign sum  = (ovf && SAT_EN == MODE_SAT) ? {DOUT_W{1'b1}} : full[DOUT_W-1:0];

endmodule

// File: rtl/accum_block.sv
// Block accumulator: sums BLOCK_LEN valid samples, publishes the block total
// on res with a one-cycle res_valid pulse, and keeps a sticky overflow flag.
module accum_block
  import accumulation_pkg::*;
#(
  parameter int  DIN_W     = 4,
  parameter int  DOUT_W    = 8,
  parameter int  BLOCK_LEN = 4,
  parameter int  SAT_EN    = MODE_SAT,
  localparam int CNT_W     = cnt_width(BLOCK_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              din_valid,
  input  logic [DIN_W-1:0]  din,
  output logic [DOUT_W-1:0] acc,
  output logic [CNT_W-1:0]  cnt,
  output logic [DOUT_W-1:0] res,
  output logic              res_valid,
  output logic              ovf
);

  state_t            state;
  logic [DOUT_W-1:0] base;
  logic [DOUT_W-1:0] sum;
  logic              add_ovf;
  logic              last;

  // A new block always starts from zero, whatever acc happens to hold.
  assign base = (state == IDLE) ? '0 : acc;
  assign last = (cnt == CNT_W'(BLOCK_LEN - 1));

  accum_sat_add #(
    .DIN_W (DIN_W),
    .DOUT_W(DOUT_W),
    .SAT_EN(SAT_EN)
  ) u_add (
    .a  (base),
    .b  (din),
    .sum(sum),
    .ovf(add_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (clr) begin
        // clr wins over a concurrent sample; res is deliberately kept.
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
      end else if (din_valid) begin
        if (add_ovf) ovf <= 1'b1;
        if (last) begin
          res       <= sum;
          res_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          state     <= IDLE;
        end else begin
          acc   <= sum;
          cnt   <= cnt + CNT_W'(1);
          state <= ACC;
        end
      end
    end
  end

endmodule

// File: tb/tb_accum_block.sv
// Directed bench for accum_block: default config plus BLOCK_LEN=32 (sat/wrap)
// and BLOCK_LEN=1 instances sharing one stimulus bus.
module tb_accum_block;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       din_valid = 1'b0;
  logic [3:0] din = '0;

  logic [7:0] acc, res;
  logic [2:0] cnt;
  logic       res_valid, ovf;

  logic [7:0] big_acc, big_res;
  logic [5:0] big_cnt;
  logic       big_rv, big_ovf;

  logic [7:0] wrp_acc, wrp_res;
  logic [5:0] wrp_cnt;
  logic       wrp_rv, wrp_ovf;

  logic [7:0] one_acc, one_res;
  logic [0:0] one_cnt;
  logic       one_rv, one_ovf;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  accum_block u_dut (
    .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
    .acc(acc), .cnt(cnt), .res(res), .res_valid(res_valid), .ovf(ovf)
  );

  accum_block #(.BLOCK_LEN(32), .SAT_EN(1)) u_big (
    .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
    .acc(big_acc), .cnt(big_cnt), .res(big_res), .res_valid(big_rv), .ovf(big_ovf)
  );

  accum_block #(.BLOCK_LEN(32), .SAT_EN(0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
    .acc(wrp_acc), .cnt(wrp_cnt), .res(wrp_res), .res_valid(wrp_rv), .ovf(wrp_ovf)
  );

  accum_block #(.BLOCK_LEN(1)) u_one (
    .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
    .acc(one_acc), .cnt(one_cnt), .res(one_res), .res_valid(one_rv), .ovf(one_ovf)
  );

  // Drive one cycle of inputs and return 1ns after the sampling edge.
  task automatic step(input logic v, input logic [3:0] d, input logic c);
    din_valid = v;
    din       = d;
    clr       = c;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; clr = 1'b0; din_valid = 1'b0; din = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if ({acc, cnt, res, res_valid, ovf} !== 21'd0)
      $display("FAIL reset_initial: got acc=%0d cnt=%0d res=%0d rv=%0b ovf=%0b expected all 0",
               acc, cnt, res, res_valid, ovf);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 4'd1, 0); step(1, 4'd2, 0); step(1, 4'd4, 0); step(1, 4'd8, 0);
    step(1, 4'd3, 0);
    total++;
    if ({acc, cnt, res} !== {8'd3, 3'd1, 8'd15})
      $display("FAIL reset_pre: got acc=%0d cnt=%0d res=%0d expected 3 1 15", acc, cnt, res);
    else passed++;
    #2;
    rst = 1'b1;
    #2;
    total++;
    if ({acc, cnt, res, res_valid, ovf} !== 21'd0)
      $display("FAIL reset_async: got acc=%0d cnt=%0d res=%0d rv=%0b ovf=%0b expected all 0",
               acc, cnt, res, res_valid, ovf);
    else passed++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1, 4'd6, 0);
    total++;
    if ({acc, cnt, res_valid} !== {8'd6, 3'd1, 1'b0})
      $display("FAIL reset_restart: got acc=%0d cnt=%0d rv=%0b expected 6 1 0", acc, cnt, res_valid);
    else passed++;
  endtask

  task automatic test_block();
    logic [3:0] dv [4];
    logic [7:0] ea [4];
    logic [2:0] ec [4];
    dv = '{4'd1, 4'd2, 4'd4, 4'd8};
    ea = '{8'd1, 8'd3, 8'd7, 8'd0};
    ec = '{3'd1, 3'd2, 3'd3, 3'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, dv[i], 0);
      total++;
      if ({acc, cnt, res_valid} !== {ea[i], ec[i], (i == 3) ? 1'b1 : 1'b0})
        $display("FAIL block_s%0d: got acc=%0d cnt=%0d rv=%0b expected %0d %0d %0b",
                 i, acc, cnt, res_valid, ea[i], ec[i], i == 3);
      else passed++;
    end
    total++;
    if (res !== 8'd15) $display("FAIL block_res: got %0d expected 15", res);
    else passed++;
    step(0, 4'd9, 0);
    total++;
    if ({res, res_valid, acc, cnt} !== {8'd15, 1'b0, 8'd0, 3'd0})
      $display("FAIL block_hold: got res=%0d rv=%0b acc=%0d cnt=%0d expected 15 0 0 0",
               res, res_valid, acc, cnt);
    else passed++;
  endtask

  task automatic test_gap();
    do_reset();
    step(1, 4'd5, 0);
    step(0, 4'd7, 0);
    total++;
    if ({acc, cnt} !== {8'd5, 3'd1}) $display("FAIL gap_hold1: got acc=%0d cnt=%0d expected 5 1", acc, cnt);
    else passed++;
    step(0, 4'd7, 0);
    total++;
    if ({acc, cnt, res_valid} !== {8'd5, 3'd1, 1'b0})
      $display("FAIL gap_hold2: got acc=%0d cnt=%0d rv=%0b expected 5 1 0", acc, cnt, res_valid);
    else passed++;
    step(1, 4'd5, 0); step(1, 4'd5, 0);
    total++;
    if ({acc, cnt} !== {8'd15, 3'd3}) $display("FAIL gap_mid: got acc=%0d cnt=%0d expected 15 3", acc, cnt);
    else passed++;
    step(1, 4'd5, 0);
    total++;
    if ({res, res_valid, acc, cnt} !== {8'd20, 1'b1, 8'd0, 3'd0})
      $display("FAIL gap_res: got res=%0d rv=%0b acc=%0d cnt=%0d expected 20 1 0 0", res, res_valid, acc, cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1, 4'd1, 0); step(1, 4'd1, 0); step(1, 4'd1, 0); step(1, 4'd1, 0);
    total++;
    if ({res, res_valid} !== {8'd4, 1'b1}) $display("FAIL b2b_res: got res=%0d rv=%0b expected 4 1", res, res_valid);
    else passed++;
    step(1, 4'd2, 0);
    total++;
    if ({acc, cnt, res_valid, res} !== {8'd2, 3'd1, 1'b0, 8'd4})
      $display("FAIL b2b_next: got acc=%0d cnt=%0d rv=%0b res=%0d expected 2 1 0 4", acc, cnt, res_valid, res);
    else passed++;
  endtask

  task automatic test_clr();
    do_reset();
    step(1, 4'd1, 0); step(1, 4'd2, 0); step(1, 4'd4, 0); step(1, 4'd8, 0);
    step(1, 4'd1, 0); step(1, 4'd1, 0); step(1, 4'd1, 0);
    step(1, 4'd1, 1);
    total++;
    if ({acc, cnt, res_valid, res, ovf} !== {8'd0, 3'd0, 1'b0, 8'd15, 1'b0})
      $display("FAIL clr_final: got acc=%0d cnt=%0d rv=%0b res=%0d ovf=%0b expected 0 0 0 15 0",
               acc, cnt, res_valid, res, ovf);
    else passed++;
    step(1, 4'd9, 0);
    total++;
    if ({acc, cnt} !== {8'd9, 3'd1}) $display("FAIL clr_restart: got acc=%0d cnt=%0d expected 9 1", acc, cnt);
    else passed++;
  endtask

  task automatic test_sat();
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 4'd15, 0);
    total++;
    if ({big_acc, big_cnt, big_ovf, wrp_acc, wrp_ovf} !== {8'd255, 6'd17, 1'b0, 8'd255, 1'b0})
      $display("FAIL sat_17: got big=%0d/%0d/%0b wrap=%0d/%0b expected 255/17/0 255/0",
               big_acc, big_cnt, big_ovf, wrp_acc, wrp_ovf);
    else passed++;
    step(1, 4'd15, 0);
    total++;
    if ({big_acc, big_cnt, big_ovf} !== {8'd255, 6'd18, 1'b1})
      $display("FAIL sat_18: got acc=%0d cnt=%0d ovf=%0b expected 255 18 1", big_acc, big_cnt, big_ovf);
    else passed++;
    total++;
    if ({wrp_acc, wrp_ovf} !== {8'd14, 1'b1})
      $display("FAIL wrap_18: got acc=%0d ovf=%0b expected 14 1", wrp_acc, wrp_ovf);
    else passed++;
    step(1, 4'd15, 0);
    total++;
    if ({wrp_acc, wrp_ovf, big_acc, big_ovf} !== {8'd29, 1'b1, 8'd255, 1'b1})
      $display("FAIL ovf_sticky: got wrap=%0d/%0b big=%0d/%0b expected 29/1 255/1",
               wrp_acc, wrp_ovf, big_acc, big_ovf);
    else passed++;
    step(0, 4'd0, 1);
    total++;
    if ({big_acc, big_cnt, big_ovf, wrp_ovf} !== {8'd0, 6'd0, 1'b0, 1'b0})
      $display("FAIL ovf_clr: got acc=%0d cnt=%0d ovf=%0b wovf=%0b expected 0 0 0 0",
               big_acc, big_cnt, big_ovf, wrp_ovf);
    else passed++;
  endtask

  task automatic test_len1();
    do_reset();
    step(1, 4'd3, 0);
    total++;
    if ({one_res, one_rv, one_acc, one_cnt} !== {8'd3, 1'b1, 8'd0, 1'b0})
      $display("FAIL len1_a: got res=%0d rv=%0b acc=%0d cnt=%0d expected 3 1 0 0", one_res, one_rv, one_acc, one_cnt);
    else passed++;
    step(1, 4'd7, 0);
    total++;
    if ({one_res, one_rv} !== {8'd7, 1'b1}) $display("FAIL len1_b: got res=%0d rv=%0b expected 7 1", one_res, one_rv);
    else passed++;
    step(0, 4'd1, 0);
    total++;
    if ({one_res, one_rv} !== {8'd7, 1'b0}) $display("FAIL len1_idle: got res=%0d rv=%0b expected 7 0", one_res, one_rv);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_block();
    test_gap();
    test_back_to_back();
    test_clr();
    test_sat();
    test_len1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/accum_block.md
ACCUM_BLOCK -- requirements
Module: accum_block

Interface
REQ-001 Parameter DIN_W, default 4, input sample width (unsigned).
REQ-002 Parameter DOUT_W, default 8, accumulator/result width; DOUT_W >= DIN_W.
REQ-003 Parameter BLOCK_LEN, default 4, samples per block; BLOCK_LEN >= 1.
REQ-004 Parameter SAT_EN, default 1, 1 = saturate at max, 0 = wrap modulo 2^DOUT_W.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 clr  input  1  synchronous clear of acc, cnt, ovf and state.
REQ-008 din_valid  input  1  din is accumulated on this edge when high.
REQ-009 din  input  DIN_W  unsigned sample.
REQ-010 acc  output  DOUT_W  running block sum, registered.
REQ-011 cnt  output  CNT_W = clog2(BLOCK_LEN+1)  valid samples taken in current block.
REQ-012 res  output  DOUT_W  last completed block sum, held until next block completes.
REQ-013 res_valid  output  1  one-cycle pulse, res updated this cycle.
REQ-014 ovf  output  1  sticky overflow flag.

Function
REQ-015 Sum = acc + zero-extended din, computed at DOUT_W+1 bits; carry bit = overflow.
REQ-016 SAT_EN=1: on overflow acc takes 2^DOUT_W-1; SAT_EN=0: acc takes low DOUT_W bits.
REQ-017 Any overflow sets ovf; ovf clears only on clr or rst.
REQ-018 din_valid low: acc, cnt, res unchanged; res_valid low.
REQ-019 FSM states IDLE (cnt=0) and ACC (0<cnt<BLOCK_LEN); IDLE->ACC on non-final valid sample; ACC->IDLE on final sample or clr.
REQ-020 Final sample = valid sample with cnt = BLOCK_LEN-1: next edge res <= new sum (saturated/wrapped), res_valid = 1, acc <= 0, cnt <= 0, state IDLE.
REQ-021 BLOCK_LEN=1: every valid sample is final; FSM stays IDLE; res follows din with one-cycle latency.
REQ-022 Latency: acc/cnt reflect a sample one edge after it is sampled; res_valid pulses in that same cycle.
REQ-023 Back-to-back blocks: first sample of next block may arrive the cycle after the final sample with no bubble.
REQ-024 clr has priority over din_valid: concurrent sample dropped, no res_valid, res retained.
REQ-025 res_valid never high for two consecutive cycles unless BLOCK_LEN=1 with consecutive valid samples.

Reset
REQ-026 rst high immediately (no clock) forces acc=0, cnt=0, res=0, res_valid=0, ovf=0, state IDLE.
REQ-027 rst mid-block discards partial sum; first valid sample after release starts a new block at cnt=0.

Structure
REQ-028 Package accumulation_pkg holds the FSM state typedef, SAT/WRAP mode constants and the clog2 count-width function.
REQ-029 One sub-module accum_sat_add: combinational DIN_W+DOUT_W adder with SAT_EN parameter, outputs sum and overflow.
REQ-030 All registers reside in accum_block; no latches; RTL within 120-400 lines.

Verification (DIN_W=4, DOUT_W=8, BLOCK_LEN=4, SAT_EN=1 unless stated)
REQ-031 rst pulse mid-operation -> all outputs 0 asynchronously, before next clk edge.
REQ-032 din 1,2,4,8 on consecutive valid cycles -> acc 1,3,7 then 0; res=15, res_valid pulse one cycle; cnt 1,2,3,0.
REQ-033 din 5, valid low 2 cycles, then 5,5,5 -> acc holds 5 during gap; res=20 after 4th valid sample.
REQ-034 BLOCK_LEN=32, din=15 valid x18 -> acc 255 after 17th, stays 255 after 18th, ovf=1; SAT_EN=0 -> acc=14, ovf=1.
REQ-035 clr with 4th sample of a block (prior res=15) -> acc=0, cnt=0, no res_valid, res stays 15, ovf=0.
REQ-036 BLOCK_LEN=1, din 3,7 consecutive valid -> res 3 then 7, res_valid high two cycles.
